// File: rtl/regfile_ctrl_pkg.sv
// Shared definitions for the register-file write-port controller.
//   NREG / AW / DW     : geometry of the 32x32 CPU register file
//   STARVE_MAX_DEFAULT : WB wins tolerated with a debug write pending
//   rf_state_e         : controller phase (init sweep, then normal run)
package regfile_ctrl_pkg;
    localparam int NREG               = 32;
    localparam int AW                 = 5;
    localparam int DW                 = 32;
    localparam int STARVE_MAX_DEFAULT = 4;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;
endpackage

// File: rtl/rf_starve_counter.sv
// Counts consecutive cycles in which writeback took the write port while a
// debug write was waiting, and raises stall_o once the debug side has lost
// STARVE_MAX times in a row.
//   clk_50, rst_i : clock, async active-high reset
//   req           : debug request present (RUN only)
//   pending       : request eligible for grant (not in its ack cycle)
//   won           : writeback owned the port this cycle
//   granted       : debug write performed this cycle
//   stall_o       : registered pipeline stall
//   starve_cnt    : current run of lost arbitrations (saturating)
module rf_starve_counter #(
    parameter int STARVE_MAX = 4,
    parameter int CW         = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk_50,
    input  logic          rst_i,
    input  logic          req,
    input  logic          pending,
    input  logic          won,
    input  logic          granted,
    output logic          stall_o,
    output logic [CW-1:0] starve_cnt
);
    logic at_limit;
    logic lose;

    assign at_limit = (starve_cnt == CW'(STARVE_MAX - 1));
    assign lose     = pending && won;

    always_ff @(posedge clk_50 or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            stall_o    <= 1'b0;
        end else begin
            // During the ack cycle the request may still be high; the count
            // then holds rather than clearing or advancing.
            if (granted || !req)
                starve_cnt <= '0;
            else if (lose && !at_limit)
                starve_cnt <= starve_cnt + 1'b1;

            // Stall persists through any further WB wins until debug is served.
            if (granted)
                stall_o <= 1'b0;
            else if (lose && at_limit)
                stall_o <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_port_ctrl.sv
// Write-port controller for the 32x32 register file. After reset it sweeps
// every register with values from an external init table, then arbitrates
// the single write port between writeback (priority) and a debug requester,
// stalling the pipeline when debug has been starved too long.
//   clk_50, rst_i              : clock, async active-high reset
//   init_addr_o / init_data_i  : init table lookup (same-cycle data)
//   wb_we_i/wb_addr_i/wb_data_i: writeback write
//   dbg_req_i/dbg_addr_i/dbg_data_i, dbg_ack_o : debug write handshake
//   rf_we_o/rf_wr_o/rf_wd_o    : register file write port (combinational)
//   busy_o  : init sweep in progress
//   stall_o : pipeline must hold wb_we_i low
//   err_o   : sticky protocol violation
module regfile_port_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic          clk_50,
    input  logic          rst_i,
    output logic [AW-1:0] init_addr_o,
    input  logic [DW-1:0] init_data_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic [DW-1:0] wb_data_i,
    input  logic          dbg_req_i,
    input  logic [AW-1:0] dbg_addr_i,
    input  logic [DW-1:0] dbg_data_i,
    output logic          dbg_ack_o,
    output logic          rf_we_o,
    output logic [AW-1:0] rf_wr_o,
    output logic [DW-1:0] rf_wd_o,
    output logic          busy_o,
    output logic          stall_o,
    output logic          err_o
);
    localparam int SCW = $clog2(STARVE_MAX + 1);

    rf_state_e     state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          in_run;
    logic          wb_win;
    logic          dbg_pending;
    logic          dbg_grant;
    logic [SCW-1:0] starve_cnt;

    assign in_run      = (state == RUN);
    assign wb_win      = in_run && wb_we_i;
    // A request still high in its ack cycle is the one just written.
    assign dbg_pending = in_run && dbg_req_i && !dbg_ack_o;
    assign dbg_grant   = dbg_pending && !wb_we_i;
    assign init_addr_o = cnt;

    always_ff @(posedge clk_50 or posedge rst_i) begin
        if (rst_i) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            cnt_nxt = cnt + 1'b1;
            if (cnt == AW'(NREG - 1))
                state_nxt = RUN;
        end
    end

    // Write-port mux. Register 0 is hard-wired zero: the sweep writes 0 there
    // and run-time writes to it are suppressed at the enable.
    always_comb begin
        rf_we_o = 1'b0;
        rf_wr_o = cnt;
        rf_wd_o = '0;
        if (rst_i) begin
            rf_we_o = 1'b0;
        end else if (!in_run) begin
            rf_we_o = 1'b1;
            rf_wr_o = cnt;
            rf_wd_o = (cnt == '0) ? '0 : init_data_i;
        end else if (wb_we_i) begin
            rf_we_o = (wb_addr_i != '0);
            rf_wr_o = wb_addr_i;
            rf_wd_o = wb_data_i;
        end else if (dbg_grant) begin
            rf_we_o = (dbg_addr_i != '0);
            rf_wr_o = dbg_addr_i;
            rf_wd_o = dbg_data_i;
        end
    end

    always_ff @(posedge clk_50 or posedge rst_i) begin
        if (rst_i) begin
            busy_o    <= 1'b1;
            dbg_ack_o <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            busy_o    <= (state_nxt == INIT);
            dbg_ack_o <= dbg_grant;
            err_o     <= err_o | (!in_run && wb_we_i) | (wb_win && stall_o);
        end
    end

    rf_starve_counter #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .clk_50     (clk_50),
        .rst_i      (rst_i),
        .req        (in_run && dbg_req_i),
        .pending    (dbg_pending),
        .won        (wb_win),
        .granted    (dbg_grant),
        .stall_o    (stall_o),
        .starve_cnt (starve_cnt)
    );

    // The count saturates one below the limit; it never reaches STARVE_MAX.
    always @(posedge clk_50) begin
        if (!rst_i) assert (int'(starve_cnt) < STARVE_MAX);
    end
endmodule

// File: tb/tb_regfile_port_ctrl.sv
module tb_regfile_port_ctrl;
    import regfile_ctrl_pkg::*;

    localparam int SMAX = 4;

    logic          clk_50 = 1'b0;
    logic          rst_i  = 1'b0;
    logic [AW-1:0] init_addr_o;
    logic [DW-1:0] init_data_i;
    logic          wb_we_i    = 1'b0;
    logic [AW-1:0] wb_addr_i  = '0;
    logic [DW-1:0] wb_data_i  = '0;
    logic          dbg_req_i  = 1'b0;
    logic [AW-1:0] dbg_addr_i = '0;
    logic [DW-1:0] dbg_data_i = '0;
    logic          dbg_ack_o, rf_we_o, busy_o, stall_o, err_o;
    logic [AW-1:0] rf_wr_o;
    logic [DW-1:0] rf_wd_o;
    logic [DW-1:0] init_base = 32'hA000_0000;

    int checks = 0;
    int errors = 0;

    always #10 clk_50 = ~clk_50;

    // External init table: value = base + register index.
    assign init_data_i = init_base + DW'(init_addr_o);

    regfile_port_ctrl #(.STARVE_MAX(SMAX)) dut (
        .clk_50(clk_50), .rst_i(rst_i),
        .init_addr_o(init_addr_o), .init_data_i(init_data_i),
        .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .dbg_req_i(dbg_req_i), .dbg_addr_i(dbg_addr_i), .dbg_data_i(dbg_data_i),
        .dbg_ack_o(dbg_ack_o),
        .rf_we_o(rf_we_o), .rf_wr_o(rf_wr_o), .rf_wd_o(rf_wd_o),
        .busy_o(busy_o), .stall_o(stall_o), .err_o(err_o)
    );

    // Each cycle starts 1 time unit after the rising edge.
    task tick;
        @(posedge clk_50);
        #1;
    endtask

    task test_reset;
        rst_i = 1'b0;
        #1;
        rst_i = 1'b1;
        wb_we_i = 1'b1; wb_addr_i = 5'd5; dbg_req_i = 1'b1; dbg_addr_i = 5'd3;
        repeat (2) tick;
        #1;
        checks++;
        if ({busy_o, stall_o, dbg_ack_o, err_o, rf_we_o} !== 5'b10000 || init_addr_o !== '0) begin
            errors++;
            $display("FAIL reset: busy/stall/ack/err/we=%b init_addr=%0d, want 10000 0",
                     {busy_o, stall_o, dbg_ack_o, err_o, rf_we_o}, init_addr_o);
        end
        wb_we_i = 1'b0; dbg_req_i = 1'b0;
    endtask

    task release_rst;
        tick;
        rst_i = 1'b0;
    endtask

    task test_init_sweep;
        logic [DW-1:0] wd;
        for (int i = 0; i < NREG; i++) begin
            #1;
            wd = (i == 0) ? 32'h0 : 32'hA000_0000 + DW'(i);
            checks++;
            if (rf_we_o !== 1'b1 || rf_wr_o !== AW'(i) || rf_wd_o !== wd || busy_o !== 1'b1) begin
                errors++;
                $display("FAIL init_sweep[%0d]: we=%b wr=%0d wd=%h busy=%b, want 1 %0d %h 1",
                         i, rf_we_o, rf_wr_o, rf_wd_o, busy_o, i, wd);
            end
            tick;
        end
        #1;
        checks++;
        if (busy_o !== 1'b0 || rf_we_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy=%b we=%b err=%b in cycle 33, want 0 0 0", busy_o, rf_we_o, err_o);
        end
        tick;
    endtask

    task test_dbg_write;
        dbg_req_i = 1'b1; dbg_addr_i = 5'd7; dbg_data_i = 32'h1234;
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd7 || rf_wd_o !== 32'h1234 || dbg_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL dbg_grant: we=%b wr=%0d wd=%h ack=%b, want 1 7 00001234 0",
                     rf_we_o, rf_wr_o, rf_wd_o, dbg_ack_o);
        end
        tick; #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL dbg_no_rewrite: ack=%b we=%b, want 1 0", dbg_ack_o, rf_we_o);
        end
        dbg_req_i = 1'b0;
        tick; #1;
        checks++;
        if (dbg_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL dbg_ack_pulse: ack=%b, want 0", dbg_ack_o);
        end
        tick;
    endtask

    task test_starvation;
        logic [DW-1:0] d;
        dbg_req_i = 1'b1; dbg_addr_i = 5'd9; dbg_data_i = 32'h55;
        wb_we_i = 1'b1;
        for (int i = 0; i < SMAX; i++) begin
            wb_addr_i = AW'(i + 1);
            d = $urandom;
            wb_data_i = d;
            #1;
            checks++;
            if (rf_we_o !== 1'b1 || rf_wr_o !== AW'(i + 1) || rf_wd_o !== d || stall_o !== 1'b0 || dbg_ack_o !== 1'b0) begin
                errors++;
                $display("FAIL starve_wb_win[%0d]: we=%b wr=%0d wd=%h stall=%b ack=%b, want 1 %0d %h 0 0",
                         i, rf_we_o, rf_wr_o, rf_wd_o, stall_o, dbg_ack_o, i + 1, d);
            end
            tick;
        end
        checks++;
        if (stall_o !== 1'b1) begin
            errors++;
            $display("FAIL starve_stall_rise: stall=%b, want 1", stall_o);
        end
        wb_we_i = 1'b0;   // conforming pipeline obeys stall
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd9 || rf_wd_o !== 32'h55) begin
            errors++;
            $display("FAIL starve_grant: we=%b wr=%0d wd=%h, want 1 9 00000055", rf_we_o, rf_wr_o, rf_wd_o);
        end
        tick; #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || stall_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL starve_release: ack=%b stall=%b err=%b, want 1 0 0", dbg_ack_o, stall_o, err_o);
        end
        dbg_req_i = 1'b0;
        tick;
    endtask

    task test_stall_violation;
        dbg_req_i = 1'b1; dbg_addr_i = 5'd10; dbg_data_i = 32'h77;
        wb_we_i = 1'b1; wb_addr_i = 5'd2; wb_data_i = $urandom;
        repeat (SMAX) tick;
        wb_addr_i = 5'd4; wb_data_i = 32'hDEAD;
        #1;
        checks++;
        if (stall_o !== 1'b1 || rf_we_o !== 1'b1 || rf_wr_o !== 5'd4 || rf_wd_o !== 32'hDEAD || err_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_wb_still_wins: stall=%b we=%b wr=%0d wd=%h err=%b, want 1 1 4 0000dead 0",
                     stall_o, rf_we_o, rf_wr_o, rf_wd_o, err_o);
        end
        tick;
        wb_we_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1 || stall_o !== 1'b1 || rf_we_o !== 1'b1 || rf_wr_o !== 5'd10) begin
            errors++;
            $display("FAIL stall_err_set: err=%b stall=%b we=%b wr=%0d, want 1 1 1 10", err_o, stall_o, rf_we_o, rf_wr_o);
        end
        tick; #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || stall_o !== 1'b0 || err_o !== 1'b1) begin
            errors++;
            $display("FAIL stall_err_sticky: ack=%b stall=%b err=%b, want 1 0 1", dbg_ack_o, stall_o, err_o);
        end
        dbg_req_i = 1'b0;
        tick;
    endtask

    task test_init_wb_err;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        tick; tick;     // third sweep cycle, index 2
        wb_we_i = 1'b1; wb_addr_i = 5'd6; wb_data_i = 32'hBEEF;
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd2 || rf_wd_o !== 32'hA000_0002 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL init_wb_ignored: we=%b wr=%0d wd=%h err=%b, want 1 2 a0000002 0",
                     rf_we_o, rf_wr_o, rf_wd_o, err_o);
        end
        tick;
        wb_we_i = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL init_wb_err: err=%b, want 1", err_o);
        end
        for (int n = 0; n < NREG + 4 && busy_o === 1'b1; n++) tick;
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL init_wb_sweep_end: busy=%b after bounded wait, want 0", busy_o);
        end
        tick;
    endtask

    task test_dbg_addr0;
        dbg_req_i = 1'b1; dbg_addr_i = 5'd0; dbg_data_i = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || dbg_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL dbg_addr0_we: we=%b ack=%b, want 0 0", rf_we_o, dbg_ack_o);
        end
        tick; #1;
        checks++;
        if (dbg_ack_o !== 1'b1 || rf_we_o !== 1'b0) begin
            errors++;
            $display("FAIL dbg_addr0_ack: ack=%b we=%b, want 1 0", dbg_ack_o, rf_we_o);
        end
        dbg_req_i = 1'b0;
        tick;
    endtask

    task test_reset_midsweep;
        int acks;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        repeat (12) tick;
        dbg_req_i = 1'b1; dbg_addr_i = 5'd8; dbg_data_i = 32'h88;
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_wr_o !== 5'd12 || init_addr_o !== 5'd12) begin
            errors++;
            $display("FAIL midsweep_idx: we=%b wr=%0d init_addr=%0d, want 1 12 12", rf_we_o, rf_wr_o, init_addr_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({busy_o, stall_o, dbg_ack_o, err_o, rf_we_o} !== 5'b10000 || init_addr_o !== '0) begin
            errors++;
            $display("FAIL midsweep_reset: busy/stall/ack/err/we=%b init_addr=%0d, want 10000 0",
                     {busy_o, stall_o, dbg_ack_o, err_o, rf_we_o}, init_addr_o);
        end
        tick;
        rst_i = 1'b0;
        dbg_req_i = 1'b0;   // dropped request is not re-presented here
        acks = 0;
        for (int i = 0; i < NREG; i++) begin
            #1;
            checks++;
            if (rf_we_o !== 1'b1 || rf_wr_o !== AW'(i)) begin
                errors++;
                $display("FAIL midsweep_rewrite[%0d]: we=%b wr=%0d, want 1 %0d", i, rf_we_o, rf_wr_o, i);
            end
            if (dbg_ack_o === 1'b1) acks++;
            tick;
        end
        #1;
        checks++;
        if (busy_o !== 1'b0 || dbg_ack_o !== 1'b0 || acks != 0) begin
            errors++;
            $display("FAIL midsweep_no_ack: busy=%b ack=%b acks_seen=%0d, want 0 0 0", busy_o, dbg_ack_o, acks);
        end
        tick;
    endtask

    // Randomized traffic against a cycle model built from the arbitration rules.
    task test_random;
        bit            m_run, m_ack, m_stall, m_err, grant, e_we;
        int            m_idx, m_starve;
        logic [AW-1:0] e_wr;
        logic [DW-1:0] e_wd;
        init_base = $urandom;
        wb_we_i = 1'b0; dbg_req_i = 1'b0;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        m_run = 0; m_ack = 0; m_stall = 0; m_err = 0; m_idx = 0; m_starve = 0;
        for (int c = 0; c < 400; c++) begin
            if (!m_run)       wb_we_i = ($urandom_range(0, 49) == 0);
            else if (m_stall) wb_we_i = ($urandom_range(0, 9) == 0);
            else              wb_we_i = $urandom_range(0, 1) == 1;
            wb_addr_i = AW'($urandom);
            wb_data_i = $urandom;
            if (dbg_req_i && m_ack) begin
                if ($urandom_range(0, 1) == 1) dbg_req_i = 1'b0;
            end else if (!dbg_req_i && $urandom_range(0, 3) == 0) begin
                dbg_req_i = 1'b1;
                dbg_addr_i = AW'($urandom);
                dbg_data_i = $urandom;
            end
            #1;
            grant = 0; e_we = 0; e_wr = '0; e_wd = '0;
            if (!m_run) begin
                e_we = 1; e_wr = AW'(m_idx);
                e_wd = (m_idx == 0) ? 32'h0 : init_base + DW'(m_idx);
            end else if (wb_we_i) begin
                e_we = (wb_addr_i != 0); e_wr = wb_addr_i; e_wd = wb_data_i;
            end else if (dbg_req_i && !m_ack) begin
                grant = 1;
                e_we = (dbg_addr_i != 0); e_wr = dbg_addr_i; e_wd = dbg_data_i;
            end
            checks++;
            if (rf_we_o !== e_we || (e_we && (rf_wr_o !== e_wr || rf_wd_o !== e_wd)) ||
                busy_o !== !m_run || dbg_ack_o !== m_ack || stall_o !== m_stall || err_o !== m_err ||
                (!m_run && init_addr_o !== AW'(m_idx))) begin
                errors++;
                $display("FAIL random[%0d]: we=%b wr=%0d wd=%h busy=%b ack=%b stall=%b err=%b, want %b %0d %h %b %b %b %b",
                         c, rf_we_o, rf_wr_o, rf_wd_o, busy_o, dbg_ack_o, stall_o, err_o,
                         e_we, e_wr, e_wd, !m_run, m_ack, m_stall, m_err);
            end
            if (wb_we_i && (!m_run || m_stall)) m_err = 1;
            if (m_run && dbg_req_i && !m_ack && wb_we_i) begin
                m_starve++;
                if (m_starve >= SMAX) m_stall = 1;
            end
            if (grant) begin m_starve = 0; m_stall = 0; end
            if (!(m_run && dbg_req_i)) m_starve = 0;
            m_ack = grant;
            if (!m_run) begin
                m_idx++;
                if (m_idx == NREG) m_run = 1;
            end
            tick;
        end
        wb_we_i = 1'b0; dbg_req_i = 1'b0;
    endtask

    initial begin
        test_reset;
        release_rst;
        test_init_sweep;
        test_dbg_write;
        test_starvation;
        test_stall_violation;
        test_init_wb_err;
        test_dbg_addr0;
        test_reset_midsweep;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end
endmodule
